// File: rtl/gcd_arbiter.sv
// gcd_arbiter: round-robin arbiter that shares one GCD unit between two requesters.
// Optional WAIT-state watchdog is built when GCD_ARB_TIMEOUT_EN is defined.
module gcd_arbiter #(
    parameter int unsigned WIDTH          = 4,
    parameter int unsigned TIMEOUT_CYCLES = 64
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             req0_i,
    input  logic             req1_i,
    input  logic [WIDTH-1:0] x0_i,
    input  logic [WIDTH-1:0] y0_i,
    input  logic [WIDTH-1:0] x1_i,
    input  logic [WIDTH-1:0] y1_i,
    input  logic             ack0_i,
    input  logic             ack1_i,
    input  logic [WIDTH-1:0] gcd_out_i,
    input  logic             gcd_done_i,
    output logic             gnt0_o,
    output logic             gnt1_o,
    output logic             rdy0_o,
    output logic             rdy1_o,
    output logic [WIDTH-1:0] res0_o,
    output logic [WIDTH-1:0] res1_o,
    output logic [WIDTH-1:0] gcd_x_o,
    output logic [WIDTH-1:0] gcd_y_o,
    output logic             gcd_start_o,
    output logic             gcd_reset_o,
    output logic             busy_o,
    output logic             err_o
);

    if (TIMEOUT_CYCLES < 1) begin : g_bad_timeout
        $error("TIMEOUT_CYCLES must be at least 1");
    end

    typedef enum logic [2:0] {
        S_IDLE,
        S_CLR,
        S_LAUNCH,
        S_WAIT,
        S_RESP
    } state_e;

    state_e           state_q;
    logic             owner_q;
    logic             last_q;
    logic [WIDTH-1:0] gcd_x_q;
    logic [WIDTH-1:0] gcd_y_q;
    logic [WIDTH-1:0] res0_q;
    logic [WIDTH-1:0] res1_q;
    logic             rdy0_q;
    logic             rdy1_q;
    logic             start_q;
    logic             clr_q;
    logic             busy_q;

    logic             grant0_c;
    logic             grant1_c;
    logic [WIDTH-1:0] op_x_c;
    logic [WIDTH-1:0] op_y_c;
    logic             bypass_c;
    logic             ack_own_c;
    logic             fin_c;
    logic             fin_own_c;
    logic [WIDTH-1:0] res_d;

`ifdef GCD_ARB_TIMEOUT_EN
    localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES + 1);
    logic [CNT_W-1:0] wd_cnt_q;
    logic             err_q;
    logic             timeout_c;
`endif

    // Round-robin pick in IDLE; last_q=1 means requester 1 was served last.
    always_comb begin
        grant0_c = 1'b0;
        grant1_c = 1'b0;
        if (state_q == S_IDLE && !rst_i) begin
            if (req0_i && (!req1_i || last_q)) begin
                grant0_c = 1'b1;
            end else if (req1_i) begin
                grant1_c = 1'b1;
            end
        end
    end

    assign op_x_c    = grant1_c ? x1_i : x0_i;
    assign op_y_c    = grant1_c ? y1_i : y0_i;
    assign bypass_c  = (op_x_c == '0) || (op_y_c == '0);
    assign ack_own_c = owner_q ? ack1_i : ack0_i;

    // Result capture: zero bypass straight from IDLE, or GCD completion/timeout in WAIT.
    always_comb begin
        fin_c     = 1'b0;
        fin_own_c = owner_q;
        res_d     = '0;
`ifdef GCD_ARB_TIMEOUT_EN
        timeout_c = 1'b0;
`endif
        case (state_q)
            S_IDLE: begin
                fin_own_c = grant1_c;
                if ((grant0_c || grant1_c) && bypass_c) begin
                    fin_c = 1'b1;
                    res_d = op_x_c | op_y_c;
                end
            end
            S_WAIT: begin
                if (gcd_done_i) begin
                    fin_c = 1'b1;
                    res_d = gcd_out_i;
                end
`ifdef GCD_ARB_TIMEOUT_EN
                else if (wd_cnt_q == CNT_W'(TIMEOUT_CYCLES - 1)) begin
                    fin_c     = 1'b1;
                    timeout_c = 1'b1;
                end
`endif
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= S_IDLE;
            owner_q <= 1'b0;
            last_q  <= 1'b1;
            gcd_x_q <= '0;
            gcd_y_q <= '0;
            res0_q  <= '0;
            res1_q  <= '0;
            rdy0_q  <= 1'b0;
            rdy1_q  <= 1'b0;
            start_q <= 1'b0;
            clr_q   <= 1'b0;
            busy_q  <= 1'b0;
`ifdef GCD_ARB_TIMEOUT_EN
            wd_cnt_q <= '0;
            err_q    <= 1'b0;
`endif
        end else begin
            start_q <= 1'b0;
            clr_q   <= 1'b0;
`ifdef GCD_ARB_TIMEOUT_EN
            err_q   <= timeout_c;
`endif
            case (state_q)
                S_IDLE: begin
                    if (grant0_c || grant1_c) begin
                        owner_q <= grant1_c;
                        last_q  <= grant1_c;
                        gcd_x_q <= op_x_c;
                        gcd_y_q <= op_y_c;
                        busy_q  <= 1'b1;
                        clr_q   <= !bypass_c;
                        state_q <= bypass_c ? S_RESP : S_CLR;
                    end
                end
                S_CLR: begin
                    start_q <= 1'b1;
                    state_q <= S_LAUNCH;
                end
                S_LAUNCH: begin
`ifdef GCD_ARB_TIMEOUT_EN
                    wd_cnt_q <= '0;
`endif
                    state_q <= S_WAIT;
                end
                S_WAIT: begin
                    if (fin_c) begin
                        state_q <= S_RESP;
                    end
`ifdef GCD_ARB_TIMEOUT_EN
                    else begin
                        wd_cnt_q <= wd_cnt_q + CNT_W'(1);
                    end
`endif
                end
                S_RESP: begin
                    if (ack_own_c) begin
                        state_q <= S_IDLE;
                        busy_q  <= 1'b0;
                        rdy0_q  <= 1'b0;
                        rdy1_q  <= 1'b0;
                        res0_q  <= '0;
                        res1_q  <= '0;
                    end
                end
                default: state_q <= S_IDLE;
            endcase

            if (fin_c) begin
                if (fin_own_c) begin
                    rdy1_q <= 1'b1;
                    res1_q <= res_d;
                end else begin
                    rdy0_q <= 1'b1;
                    res0_q <= res_d;
                end
            end
        end
    end

    assign gnt0_o      = grant0_c;
    assign gnt1_o      = grant1_c;
    assign rdy0_o      = rdy0_q;
    assign rdy1_o      = rdy1_q;
    assign res0_o      = res0_q;
    assign res1_o      = res1_q;
    assign gcd_x_o     = gcd_x_q;
    assign gcd_y_o     = gcd_y_q;
    assign gcd_start_o = start_q;
    // The GCD unit is held cleared for the whole reset, not just its first cycle.
    assign gcd_reset_o = rst_i | clr_q;
    assign busy_o      = busy_q;
`ifdef GCD_ARB_TIMEOUT_EN
    assign err_o       = err_q;
`else
    assign err_o       = 1'b0;
`endif

endmodule

// File: tb/tb_gcd_arbiter.sv
// tb_gcd_arbiter: directed and random stimulus against a transaction-level model of the arbiter,
// with a behavioural GCD unit attached to the shared-unit ports.
`timescale 1ns/1ps
module tb_gcd_arbiter;
    localparam int unsigned W  = 4;
    localparam int unsigned TO = 64;

    logic         clk = 1'b0;
    logic         rst;
    logic         req0, req1, ack0, ack1, gcd_done;
    logic [W-1:0] x0, y0, x1, y1, gcd_out;
    logic         gnt0, gnt1, rdy0, rdy1, gcd_start, gcd_reset, busy, err;
    logic [W-1:0] res0, res1, gcd_x, gcd_y;

    int n_checks = 0;
    int n_pass   = 0;
    bit gcd_stall = 1'b0;
    int lat_lo = 1;
    int lat_hi = 5;

    gcd_arbiter #(.WIDTH(W), .TIMEOUT_CYCLES(TO)) dut (
        .clk_i(clk), .rst_i(rst),
        .req0_i(req0), .req1_i(req1),
        .x0_i(x0), .y0_i(y0), .x1_i(x1), .y1_i(y1),
        .ack0_i(ack0), .ack1_i(ack1),
        .gcd_out_i(gcd_out), .gcd_done_i(gcd_done),
        .gnt0_o(gnt0), .gnt1_o(gnt1),
        .rdy0_o(rdy0), .rdy1_o(rdy1),
        .res0_o(res0), .res1_o(res1),
        .gcd_x_o(gcd_x), .gcd_y_o(gcd_y),
        .gcd_start_o(gcd_start), .gcd_reset_o(gcd_reset),
        .busy_o(busy), .err_o(err)
    );

    always #5 clk = ~clk;

    function automatic void chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    endfunction

    function automatic logic [W-1:0] gcd_f(input logic [W-1:0] a_in, input logic [W-1:0] b_in);
        logic [W-1:0] a, b, t;
        a = a_in;
        b = b_in;
        while (b != '0) begin
            t = a % b;
            a = b;
            b = t;
        end
        return a;
    endfunction

    function automatic logic [W-1:0] rnd_op();
        if ($urandom_range(0, 5) == 0) return '0;
        return W'($urandom_range(1, (1 << W) - 1));
    endfunction

    // Behavioural GCD unit: latches operands on start, answers after a few cycles.
    int           u_cd = 0;
    logic [W-1:0] u_x, u_y;
    initial begin
        gcd_done = 1'b0;
        gcd_out  = '0;
        forever begin
            @(negedge clk);
            if (rst) u_cd = 0;
            else if (gcd_start) begin
                u_x  = gcd_x;
                u_y  = gcd_y;
                u_cd = gcd_stall ? 0 : $urandom_range(lat_lo, lat_hi);
            end
            @(posedge clk);
            #1;
            if (u_cd == 1) begin
                gcd_done = 1'b1;
                gcd_out  = gcd_f(u_x, u_y);
                u_cd     = 0;
            end else begin
                gcd_done = 1'b0;
                gcd_out  = W'($urandom);
                if (u_cd > 1) u_cd--;
            end
        end
    end

    // Transaction model: each grant is stamped with its cycle; every output follows from the stamps.
    int           cyc = 0;
    bit           m_busy = 1'b0;
    logic         m_own = 1'b0;
    logic         m_last = 1'b1;
    int           m_g = 0, m_resp_c = -1, d = 0;
    logic [W-1:0] m_x, m_y, m_res, m_gx = '0, m_gy = '0;
    bit           m_byp = 1'b0, m_to = 1'b0, in_resp = 1'b0;
    logic         e_gnt0, e_gnt1, e_rdy0, e_rdy1, e_start, e_clr, e_busy, e_err;
    logic [W-1:0] e_res0, e_res1;

    initial begin
        forever begin
            @(negedge clk);
            cyc++;
            e_gnt0 = 0; e_gnt1 = 0; e_rdy0 = 0; e_rdy1 = 0; e_start = 0;
            e_clr = 0; e_busy = 0; e_err = 0; e_res0 = '0; e_res1 = '0;
            in_resp = 1'b0;
            d = 0;
            if (rst) begin
                m_busy = 1'b0; m_last = 1'b1; m_gx = '0; m_gy = '0;
                e_clr = 1'b1;
            end else if (!m_busy) begin
                e_gnt0 = req0 && (!req1 || m_last);
                e_gnt1 = req1 && !e_gnt0;
            end else begin
                d       = cyc - m_g;
                e_busy  = 1'b1;
                in_resp = (m_resp_c >= 0) && (cyc >= m_resp_c);
                e_clr   = !m_byp && d == 1;
                e_start = !m_byp && d == 2;
                e_err   = in_resp && cyc == m_resp_c && m_to;
                if (in_resp) begin
                    if (m_own) begin e_rdy1 = 1'b1; e_res1 = m_res; end
                    else begin e_rdy0 = 1'b1; e_res0 = m_res; end
                end
            end
            chk("gnt0", 32'(gnt0), 32'(e_gnt0));
            chk("gnt1", 32'(gnt1), 32'(e_gnt1));
            chk("rdy0", 32'(rdy0), 32'(e_rdy0));
            chk("rdy1", 32'(rdy1), 32'(e_rdy1));
            chk("res0", 32'(res0), 32'(e_res0));
            chk("res1", 32'(res1), 32'(e_res1));
            chk("gcd_start", 32'(gcd_start), 32'(e_start));
            chk("gcd_reset", 32'(gcd_reset), 32'(e_clr));
            chk("busy", 32'(busy), 32'(e_busy));
            chk("err", 32'(err), 32'(e_err));
            chk("gcd_x", 32'(gcd_x), 32'(m_gx));
            chk("gcd_y", 32'(gcd_y), 32'(m_gy));
            if (rst) begin
            end else if (!m_busy) begin
                if (e_gnt0 || e_gnt1) begin
                    m_busy   = 1'b1;
                    m_own    = e_gnt1;
                    m_last   = e_gnt1;
                    m_g      = cyc;
                    m_x      = e_gnt1 ? x1 : x0;
                    m_y      = e_gnt1 ? y1 : y0;
                    m_gx     = m_x;
                    m_gy     = m_y;
                    m_res    = gcd_f(m_x, m_y);
                    m_byp    = (m_x == '0) || (m_y == '0);
                    m_to     = 1'b0;
                    m_resp_c = m_byp ? cyc + 1 : -1;
                end
            end else if (m_resp_c < 0) begin
                if (d >= 3 && gcd_done) m_resp_c = cyc + 1;
`ifdef GCD_ARB_TIMEOUT_EN
                else if (d == 3 + int'(TO) - 1) begin
                    m_resp_c = cyc + 1;
                    m_res    = '0;
                    m_to     = 1'b1;
                end
`endif
            end else if (in_resp && (m_own ? ack1 : ack0)) begin
                m_busy = 1'b0;
            end
        end
    end

    task automatic nxt();
        @(posedge clk);
        #1;
    endtask

    // Returns at the falling edge of the first cycle with RDYn high, or flags a timeout.
    task automatic wait_rdy(input int n, input string nm);
        int k;
        k = 0;
        forever begin
            @(negedge clk);
            if ((n == 0) ? rdy0 : rdy1) break;
            k++;
            if (k >= 120) begin
                chk(nm, 32'((n == 0) ? rdy0 : rdy1), 32'd1);
                break;
            end
            nxt();
        end
    endtask

    task automatic do_ack(input int n);
        nxt();
        if (n == 0) ack0 = 1'b1; else ack1 = 1'b1;
        @(negedge clk);
        nxt();
        ack0 = 1'b0;
        ack1 = 1'b0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        nxt();
        nxt();
        rst = 1'b0;
    endtask

    int k;
    initial begin
        rst = 1'b1;
        req0 = 0; req1 = 0; ack0 = 0; ack1 = 0;
        x0 = '0; y0 = '0; x1 = '0; y1 = '0;
        repeat (3) @(posedge clk);
        #1;
        @(negedge clk);
        chk("rst_gcd_reset", 32'(gcd_reset), 32'd1);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_rdy0", 32'(rdy0), 32'd0);
        nxt();
        rst = 1'b0;

        // Single request, full GCD path
        lat_lo = 3; lat_hi = 3;
        req0 = 1; x0 = 4'd12; y0 = 4'd9;
        @(negedge clk); chk("t1_gnt0", 32'(gnt0), 32'd1);
        nxt(); req0 = 0; x0 = '0; y0 = '0;
        @(negedge clk); chk("t1_clr", 32'(gcd_reset), 32'd1); chk("t1_gx", 32'(gcd_x), 32'd12);
        nxt();
        @(negedge clk); chk("t1_start", 32'(gcd_start), 32'd1);
        nxt();
        wait_rdy(0, "t1_rdy_wait");
        chk("t1_res0", 32'(res0), 32'd3);
        do_ack(0);
        @(negedge clk); chk("t1_rdy_fall", 32'(rdy0), 32'd0);
        nxt();

        // Tie after reset, then alternation
        do_reset();
        req0 = 1; x0 = 4'd15; y0 = 4'd4; req1 = 1; x1 = 4'd8; y1 = 4'd12;
        @(negedge clk); chk("t2_tie_gnt0", 32'(gnt0), 32'd1); chk("t2_tie_gnt1", 32'(gnt1), 32'd0);
        nxt(); req0 = 0;
        wait_rdy(0, "t2_rdy0_wait");
        chk("t2_res0", 32'(res0), 32'd1); chk("t2_res1_idle", 32'(res1), 32'd0);
        nxt(); ack0 = 1;
        @(negedge clk);
        nxt(); ack0 = 0;
        @(negedge clk); chk("t2_gnt1", 32'(gnt1), 32'd1);
        nxt(); req1 = 0;
        wait_rdy(1, "t2_rdy1_wait");
        chk("t2_res1", 32'(res1), 32'd4);
        nxt(); ack1 = 1;
        @(negedge clk);
        nxt(); ack1 = 0; req0 = 1; req1 = 1;
        @(negedge clk); chk("t2_tie2_gnt0", 32'(gnt0), 32'd1);
        nxt(); req0 = 0; req1 = 0;
        wait_rdy(0, "t2_rdy0b_wait");
        do_ack(0);

        // Zero-operand bypass
        req1 = 1; x1 = 4'd0; y1 = 4'd7;
        @(negedge clk); chk("t3_gnt1", 32'(gnt1), 32'd1);
        nxt(); req1 = 0;
        @(negedge clk);
        chk("t3_rdy1", 32'(rdy1), 32'd1); chk("t3_res1", 32'(res1), 32'd7);
        chk("t3_start", 32'(gcd_start), 32'd0);
        do_ack(1);

        // Reset while waiting on the GCD unit
        gcd_stall = 1;
        req0 = 1; x0 = 4'd12; y0 = 4'd9;
        @(negedge clk);
        nxt(); req0 = 0;
        repeat (4) @(posedge clk);
        #1;
        rst = 1;
        @(negedge clk);
        chk("t4_gcd_reset", 32'(gcd_reset), 32'd1); chk("t4_busy", 32'(busy), 32'd0);
        chk("t4_gx", 32'(gcd_x), 32'd0); chk("t4_rdy0", 32'(rdy0), 32'd0);
        nxt(); rst = 0; gcd_stall = 0;
        req0 = 1; x0 = 4'd6; y0 = 4'd4;
        @(negedge clk); chk("t4_gnt0", 32'(gnt0), 32'd1);
        nxt(); req0 = 0;
        wait_rdy(0, "t4_rdy_wait");
        chk("t4_res0", 32'(res0), 32'd2);
        do_ack(0);

        // Owner stalls ACK while the other requester waits
        req0 = 1; x0 = 4'd9; y0 = 4'd6;
        @(negedge clk); chk("t5_gnt0", 32'(gnt0), 32'd1);
        nxt(); req0 = 0; req1 = 1; x1 = 4'd5; y1 = 4'd10;
        wait_rdy(0, "t5_rdy_wait");
        for (int i = 0; i < 20; i++) begin
            chk("t5_res0_hold", 32'(res0), 32'd3);
            chk("t5_gnt1_low", 32'(gnt1), 32'd0);
            nxt();
            @(negedge clk);
        end
        nxt(); ack0 = 1;
        @(negedge clk);
        nxt(); ack0 = 0;
        @(negedge clk); chk("t5_gnt1", 32'(gnt1), 32'd1);
        nxt(); req1 = 0;
        wait_rdy(1, "t5_rdy1_wait");
        chk("t5_res1", 32'(res1), 32'd5);
        do_ack(1);

`ifdef GCD_ARB_TIMEOUT_EN
        // Watchdog: GCD unit never answers
        gcd_stall = 1;
        req0 = 1; x0 = 4'd12; y0 = 4'd9;
        @(negedge clk); chk("t6_gnt0", 32'(gnt0), 32'd1);
        nxt(); req0 = 0;
        k = 1;
        forever begin
            @(negedge clk);
            if (err) break;
            k++;
            if (k > 200) begin
                chk("t6_err_wait", 32'(err), 32'd1);
                break;
            end
            nxt();
        end
        chk("t6_err_cycle", 32'(k), 32'd67);
        chk("t6_rdy0", 32'(rdy0), 32'd1);
        chk("t6_res0", 32'(res0), 32'd0);
        do_ack(0);
        gcd_stall = 0;
`endif

        // Random traffic
        lat_lo = 1; lat_hi = 5;
        for (int i = 0; i < 3000; i++) begin
            nxt();
            if (req0) begin if ($urandom_range(0, 7) == 0) req0 = 0; end
            else if ($urandom_range(0, 3) == 0) req0 = 1;
            if (req1) begin if ($urandom_range(0, 7) == 0) req1 = 0; end
            else if ($urandom_range(0, 3) == 0) req1 = 1;
            x0 = rnd_op(); y0 = rnd_op(); x1 = rnd_op(); y1 = rnd_op();
            ack0 = ($urandom_range(0, 2) == 0);
            ack1 = ($urandom_range(0, 2) == 0);
            rst  = ($urandom_range(0, 599) == 0);
        end
        nxt();
        rst = 0; req0 = 0; req1 = 0; ack0 = 0; ack1 = 0;
        repeat (4) @(posedge clk);
        @(negedge clk);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/gcd_arbiter.md
GCD_ARBITER -- requirements
Module: gcd_arbiter

Interface
REQ-001 Parameter WIDTH, default 4: operand/result width, matching the GCD datapath.
REQ-002 Parameter TIMEOUT_CYCLES, default 64: WAIT-state watchdog limit, used only with GCD_ARB_TIMEOUT_EN.
REQ-003 CLK  in  1  sole clock; all state updates on rising edge.
REQ-004 RESET  in  1  asynchronous, active-high reset.
REQ-005 REQ0, REQ1  in  1  requester n wants a GCD computation.
REQ-006 X0, Y0, X1, Y1  in  WIDTH  requester operands.
REQ-007 GNT0, GNT1  out  1  one-cycle pulse; operands of requester n are latched this cycle.
REQ-008 RDY0, RDY1  out  1  result valid for requester n.
REQ-009 RES0, RES1  out  WIDTH  result for requester n, valid while RDYn=1.
REQ-010 ACK0, ACK1  in  1  requester n consumed the result.
REQ-011 GCD_X, GCD_Y  out  WIDTH  latched operands to the shared GCD unit.
REQ-012 GCD_START, GCD_RESET  out  1  start and clear controls to the GCD unit.
REQ-013 GCD_OUT  in  WIDTH;  GCD_DONE  in  1  GCD unit result and completion flag.
REQ-014 BUSY  out  1  high in every state except IDLE.
REQ-015 ERR  out  1  one-cycle timeout pulse; constant 0 without GCD_ARB_TIMEOUT_EN.

Function
REQ-016 FSM states IDLE, CLR, LAUNCH, WAIT, RESP; exactly one requester owns the GCD unit from grant to ACK.
REQ-017 IDLE: if any REQn is high, grant, pulse GNTn, and latch Xn/Yn into GCD_X/GCD_Y; else remain in IDLE.
REQ-018 Round robin: if both requests are high, grant the requester not served last; the last-served pointer resets to 1, so requester 0 wins the first tie.
REQ-019 Zero bypass: if a latched operand is 0, the result is the other operand (0 if both are 0); the FSM goes IDLE->RESP, RDYn rises at grant+1, and GCD_START/GCD_RESET stay low.
REQ-020 Otherwise IDLE->CLR: GCD_RESET=1 for exactly one cycle (grant+1).
REQ-021 CLR->LAUNCH: GCD_START=1 for exactly one cycle (grant+2); GCD_X/GCD_Y are held stable from grant+1 until the FSM leaves WAIT.
REQ-022 LAUNCH->WAIT; WAIT holds until GCD_DONE is sampled high, then GCD_OUT is latched and the FSM moves to RESP.
REQ-023 RESP: RDYn=1 and RESn is held stable until ACKn is sampled high; the FSM then returns to IDLE and RDYn falls on the next cycle.
REQ-024 ACKn while RDYn=0, and ACK of the non-owning requester, have no effect.
REQ-025 A REQn dropped before grant is ignored; a REQn still high after its ACK competes again under round robin.
REQ-026 The non-owning requester waits with GNT low regardless of how long the owner stalls ACK.
REQ-027 Unselected RESn reads 0; GNT/RDY are never high for both requesters at once.

Reset
REQ-028 RESET high: FSM=IDLE, pointer=1, operands and results=0, GNT/RDY/GCD_START/BUSY/ERR=0, and the watchdog counter=0.
REQ-029 GCD_RESET is driven high combinationally for as long as RESET is high.
REQ-030 A RESET mid-operation abandons the transaction; no RDY or ERR is issued for it.

Configuration
REQ-031 With macro GCD_ARB_TIMEOUT_EN defined: a counter clears on WAIT entry and increments each WAIT cycle.
REQ-032 With GCD_ARB_TIMEOUT_EN defined: if TIMEOUT_CYCLES WAIT cycles elapse without GCD_DONE, ERR pulses one cycle, the result is forced to 0, and the FSM enters RESP.
REQ-033 Without GCD_ARB_TIMEOUT_EN: no counter is built, WAIT waits indefinitely, and ERR is tied 0.

Verification
REQ-034 REQ0 with X0=12, Y0=9 -> GNT0 pulse, GCD_RESET at +1, GCD_START at +2, RDY0 with RES0=3 one cycle after GCD_DONE; RDY0 falls after ACK0.
REQ-035 REQ0 (15,4) and REQ1 (8,12) in the same cycle after reset -> port 0 served first (RES0=1), then port 1 (RES1=4); next tie goes to port 0.
REQ-036 REQ1 with X1=0, Y1=7 -> RDY1 at grant+1 with RES1=7; GCD_START never asserted.
REQ-037 RESET asserted in WAIT -> all outputs 0 and GCD_RESET high; after release, REQ0 (6,4) -> RES0=2.
REQ-038 ACK0 held low 20 cycles with REQ1 pending -> RES0 stable, GNT1 low throughout; GNT1 pulses in the IDLE cycle after ACK0.
REQ-039 With GCD_ARB_TIMEOUT_EN: GCD_DONE held low -> ERR pulse 64 cycles after WAIT entry, RDY0=1 with RES0=0.
